// File: rtl/icache_types.sv
// Shared types for the L1 instruction cache: FSM state, line geometry and
// the word-select helper used on the read path.
package icache_types;

  typedef enum logic {LOOKUP, FILL} icache_state_t;

  localparam int ICACHE_LINE_BITS = 256;
  localparam int ICACHE_OFS_BITS  = 5;

  typedef logic [ICACHE_LINE_BITS-1:0] icache_line_t;

  // Word w of a line sits at bits [32w+31:32w].
  function automatic logic [31:0] line_word(icache_line_t line, logic [2:0] w_sel);
    return line[{w_sel, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped I-cache: combinational read,
// one write port, whole-array invalidate. Only the valid bits are reset.
module icache_array
  import icache_types::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IDX_BITS-1:0]         rd_idx,
  output logic                        rd_valid,
  output logic [TAG_BITS-1:0]         rd_tag,
  output logic [ICACHE_LINE_BITS-1:0] rd_line,
  input  logic                        we,
  input  logic [IDX_BITS-1:0]         wr_idx,
  input  logic [TAG_BITS-1:0]         wr_tag,
  input  logic [ICACHE_LINE_BITS-1:0] wr_line,
  input  logic                        flush_all
);

  logic [NUM_SETS-1:0]         valid_q;
  logic [NUM_SETS-1:0]         valid_d;
  logic [TAG_BITS-1:0]         tag_q  [NUM_SETS];
  logic [ICACHE_LINE_BITS-1:0] data_q [NUM_SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Invalidate takes priority over a same-cycle install.
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_idx] = 1'b1;
    if (flush_all) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped read-only L1 I-cache: 1-cycle registered hit path, miss
// stalls fetch and refills one whole line from pmem, then replays the lookup.
module icache_l1
  import icache_types::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         imem_read,
  input  logic [31:0]  imem_address,
  input  logic         imem_stall,
  input  logic         flush,
  output logic         imem_resp,
  output logic         imem_ready,
  output logic [31:0]  imem_rdata,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int OFS_BITS = $clog2(LINE_BYTES);
  localparam int TAG_BITS = 32 - IDX_BITS - OFS_BITS;

  icache_state_t       state_q, state_d;
  logic                imem_ready_q, imem_ready_d;
  logic [31:0]         imem_rdata_q, imem_rdata_d;
  logic                pmem_read_q, pmem_read_d;
  logic [TAG_BITS-1:0] fill_tag_q, fill_tag_d;
  logic [IDX_BITS-1:0] fill_idx_q, fill_idx_d;
  logic                fill_flushed_q, fill_flushed_d;

  logic [2:0]            req_word;
  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  unused_addr;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  icache_line_t          rd_line;
  logic                  hit;
  logic                  lookup_go;
  logic                  start_fill;
  logic                  array_we;

  assign req_word    = imem_address[OFS_BITS-1:2];
  assign req_idx     = imem_address[IDX_BITS+OFS_BITS-1:OFS_BITS];
  assign req_tag     = imem_address[31:IDX_BITS+OFS_BITS];
  assign unused_addr = ^imem_address[1:0];

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .we        (array_we),
    .wr_idx    (fill_idx_q),
    .wr_tag    (fill_tag_q),
    .wr_line   (pmem_rdata),
    .flush_all (flush)
  );

  assign hit        = rd_valid && (rd_tag == req_tag);
  assign lookup_go  = (state_q == LOOKUP) && !imem_stall && imem_read;
  assign imem_resp  = !rst && lookup_go && hit;
  assign start_fill = lookup_go && !hit;
  // A fill that saw a flush (now or earlier) must not resurrect stale code.
  assign array_we   = (state_q == FILL) && pmem_resp && !flush && !fill_flushed_q;

  assign imem_ready   = imem_ready_q;
  assign imem_rdata   = imem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = {fill_tag_q, fill_idx_q, {ICACHE_OFS_BITS{1'b0}}};

  always_comb begin
    state_d        = state_q;
    imem_ready_d   = imem_ready_q;
    imem_rdata_d   = imem_rdata_q;
    pmem_read_d    = pmem_read_q;
    fill_tag_d     = fill_tag_q;
    fill_idx_d     = fill_idx_q;
    fill_flushed_d = fill_flushed_q;
    case (state_q)
      LOOKUP: begin
        if (!imem_stall) begin
          imem_ready_d = imem_resp;
          if (imem_resp) imem_rdata_d = line_word(rd_line, req_word);
          if (start_fill) begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            fill_tag_d     = req_tag;
            fill_idx_d     = req_idx;
            fill_flushed_d = 1'b0;
          end
        end
      end
      FILL: begin
        imem_ready_d = 1'b0;
        if (flush) fill_flushed_d = 1'b1;
        if (pmem_resp) begin
          state_d     = LOOKUP;
          pmem_read_d = 1'b0;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOOKUP;
      imem_ready_q   <= 1'b0;
      imem_rdata_q   <= '0;
      pmem_read_q    <= 1'b0;
      fill_tag_q     <= '0;
      fill_idx_q     <= '0;
      fill_flushed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      imem_ready_q   <= imem_ready_d;
      imem_rdata_q   <= imem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      fill_tag_q     <= fill_tag_d;
      fill_idx_q     <= fill_idx_d;
      fill_flushed_q <= fill_flushed_d;
    end
  end

endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: refill, hit streaming, conflict, stall,
// flush interactions and reset during a refill.
module tb_icache_l1;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_read;
  logic [31:0]  imem_address;
  logic         imem_stall;
  logic         flush;
  logic         imem_resp;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  int tests = 0;
  int fails = 0;

  icache_l1 dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_stall   (imem_stall),
    .flush        (flush),
    .imem_resp    (imem_resp),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word w of the line at base holds base+4w (the word's own address).
  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + 32'(4*w);
    return l;
  endfunction

  task automatic pmem_return(input logic [255:0] line);
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    #1;
  endtask

  logic [255:0] line60;

  initial begin
    line60 = mk_line(32'h60);
    line60[31:0] = 32'h0000_0013;
    rst = 1'b1; imem_read = 1'b0; imem_address = '0; imem_stall = 1'b0;
    flush = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    step(); step();
    chk("rst_resp",   {31'b0, imem_resp},  32'd0);
    chk("rst_ready",  {31'b0, imem_ready}, 32'd0);
    chk("rst_rdata",  imem_rdata,          32'd0);
    chk("rst_pread",  {31'b0, pmem_read},  32'd0);
    chk("rst_paddr",  pmem_address,        32'd0);
    rst = 1'b0;

    // 1: cold miss on 0x60, refill after a delay, replay hits
    imem_read = 1'b1; imem_address = 32'h60; #1;
    chk("t1_miss_resp", {31'b0, imem_resp}, 32'd0);
    step();
    chk("t1_pread",   {31'b0, pmem_read},  32'd1);
    chk("t1_paddr",   pmem_address,        32'h60);
    chk("t1_fill_resp", {31'b0, imem_resp}, 32'd0);
    chk("t1_fill_ready", {31'b0, imem_ready}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("t1_pread_held", {31'b0, pmem_read}, 32'd1);
    pmem_return(line60);
    chk("t1_replay_resp", {31'b0, imem_resp}, 32'd1);
    chk("t1_pread_drop",  {31'b0, pmem_read}, 32'd0);
    step();
    chk("t1_ready", {31'b0, imem_ready}, 32'd1);
    chk("t1_rdata", imem_rdata,          32'h0000_0013);

    // 2: back-to-back hits in the same line
    imem_address = 32'h64; #1;
    chk("t2_resp64", {31'b0, imem_resp}, 32'd1);
    step();
    chk("t2_rdata64", imem_rdata, 32'h64);
    imem_address = 32'h68; #1;
    chk("t2_resp68", {31'b0, imem_resp}, 32'd1);
    step();
    chk("t2_rdata68", imem_rdata,          32'h68);
    chk("t2_ready",   {31'b0, imem_ready}, 32'd1);
    chk("t2_pread",   {31'b0, pmem_read},  32'd0);

    // 3: conflict in index 3 evicts 0x60
    imem_address = 32'h260; #1;
    chk("t3_miss_resp", {31'b0, imem_resp}, 32'd0);
    step();
    chk("t3_ready0", {31'b0, imem_ready}, 32'd0);
    chk("t3_paddr",  pmem_address,        32'h260);
    pmem_return(mk_line(32'h260));
    chk("t3_replay_resp", {31'b0, imem_resp}, 32'd1);
    step();
    chk("t3_rdata", imem_rdata, 32'h260);
    imem_address = 32'h60; #1;
    chk("t3_evicted_resp", {31'b0, imem_resp}, 32'd0);
    step();
    chk("t3_paddr60", pmem_address,       32'h60);
    chk("t3_pread60", {31'b0, pmem_read}, 32'd1);
    pmem_return(line60);
    step();
    chk("t3_rdata60", imem_rdata, 32'h0000_0013);

    // 4: stall holds outputs and blocks a miss
    imem_stall = 1'b1; imem_address = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_resp", {31'b0, imem_resp}, 32'd0);
      step();
      chk("t4_ready", {31'b0, imem_ready}, 32'd1);
      chk("t4_rdata", imem_rdata,          32'h0000_0013);
      chk("t4_pread", {31'b0, pmem_read},  32'd0);
    end
    imem_stall = 1'b0; imem_address = 32'h6c; #1;
    chk("t4_after_resp", {31'b0, imem_resp}, 32'd1);
    step();
    chk("t4_after_rdata", imem_rdata, 32'h6c);

    // 5: flush coincides with pmem_resp -> line dropped, re-requested
    imem_address = 32'h80; #1;
    chk("t5_miss_resp", {31'b0, imem_resp}, 32'd0);
    step();
    chk("t5_paddr", pmem_address, 32'h80);
    flush = 1'b1;
    pmem_return(mk_line(32'h80));
    flush = 1'b0;
    chk("t5_replay_miss", {31'b0, imem_resp}, 32'd0);
    step();
    chk("t5_rereq_pread", {31'b0, pmem_read},  32'd1);
    chk("t5_rereq_paddr", pmem_address,        32'h80);
    chk("t5_ready0",      {31'b0, imem_ready}, 32'd0);
    pmem_return(mk_line(32'h80));
    chk("t5_install_resp", {31'b0, imem_resp}, 32'd1);
    step();
    chk("t5_rdata", imem_rdata, 32'h80);

    // flush with a same-cycle hit still returns data, then the line is gone
    imem_address = 32'h84; flush = 1'b1; #1;
    chk("fh_resp", {31'b0, imem_resp}, 32'd1);
    step();
    flush = 1'b0;
    chk("fh_rdata", imem_rdata,          32'h84);
    chk("fh_ready", {31'b0, imem_ready}, 32'd1);
    #1;
    chk("fh_gone_resp", {31'b0, imem_resp}, 32'd0);
    imem_read = 1'b0;
    step();
    chk("noread_ready", {31'b0, imem_ready}, 32'd0);
    chk("noread_pread", {31'b0, pmem_read},  32'd0);

    // 6: reset during a refill
    imem_read = 1'b1; imem_address = 32'h60;
    step();
    chk("t6_pread", {31'b0, pmem_read}, 32'd1);
    rst = 1'b1; #1;
    chk("t6_rst_pread", {31'b0, pmem_read},  32'd0);
    chk("t6_rst_ready", {31'b0, imem_ready}, 32'd0);
    chk("t6_rst_resp",  {31'b0, imem_resp},  32'd0);
    imem_read = 1'b0;
    step();
    rst = 1'b0;
    pmem_return(line60);
    chk("t6_late_pread", {31'b0, pmem_read}, 32'd0);
    imem_read = 1'b1; #1;
    chk("t6_miss_resp", {31'b0, imem_resp}, 32'd0);
    step();
    chk("t6_refill_pread", {31'b0, pmem_read}, 32'd1);
    chk("t6_refill_paddr", pmem_address,       32'h60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
